peg_l2_mac_tx_framer: RTL and testbench
=======================================

PEG_L2_MAC_TX_FRAMER -- requirements
Module: peg_l2_mac_tx_framer

Interface
REQ-001 The block SHALL have parameter PKT_DATA_W, default 8: packet byte width; only 8 is supported.
REQ-002 The block SHALL have parameter IFG_BYTES, default 12: idle byte-times enforced after each frame.
REQ-003 The block SHALL have port rmii_ref_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports pkt_in_valid, pkt_in_sop and pkt_in_eop, each input, 1 bit: MAC client byte stream qualifiers.
REQ-006 The block SHALL have port pkt_in_data, input, PKT_DATA_W bits: client payload byte, destination MAC first.
REQ-007 The block SHALL have port pkt_in_ready, output, 1 bit: client byte accepted when valid and ready are both high.
REQ-008 The block SHALL have ports pkt_out_valid, pkt_out_sop and pkt_out_eop, each output, 1 bit: framed stream to the RMII TX reconciliation layer.
REQ-009 The block SHALL have port pkt_out_data, output, PKT_DATA_W bits: framed byte.
REQ-010 The block SHALL have port pkt_out_ready, input, 1 bit: RS accepts the output byte.
REQ-011 The block SHALL have port frame_cnt, output, 16 bits: count of frames completed, wrapping.

Function
REQ-012 The block SHALL implement the FSM states IDLE, PRE, SFD, DATA, PAD, FCS and IFG.
REQ-013 In IDLE the block SHALL hold pkt_in_ready high only when pkt_in_valid=1 and pkt_in_sop=0, discarding orphan bytes.
REQ-014 On pkt_in_valid=1 and pkt_in_sop=1 in IDLE, the block SHALL enter PRE without consuming the byte; pkt_out_valid SHALL assert on the next cycle.
REQ-015 PRE SHALL emit 7 bytes of 0x55, the first carrying pkt_out_sop=1; SFD SHALL emit 1 byte of 0xD5.
REQ-016 All output signals SHALL be registered; an output byte SHALL advance only when pkt_out_valid=1 and pkt_out_ready=1, and the block SHALL hold data and flags stable while ready is low.
REQ-017 In DATA, pkt_in_ready SHALL equal "output register empty or being accepted", giving one byte per cycle at full throughput with no bubble.
REQ-018 In DATA, a byte received with pkt_in_sop=1 after the first byte SHALL be treated as the frame's end (forced eop).
REQ-019 An 11-bit saturating byte counter SHALL count payload bytes.
REQ-020 On the eop byte, the block SHALL enter PAD if the count is below 60 and padding is enabled; otherwise it SHALL enter FCS.
REQ-021 PAD SHALL emit 0x00 bytes until the counter reaches 60. A frame whose sop and eop fall in the same cycle SHALL produce 59 pad bytes.
REQ-022 The CRC-32 SHALL be computed over payload and pad using polynomial 0x04C11DB7 (reflected), with initial value 0xFFFFFFFF.
REQ-023 FCS SHALL emit the complemented CRC as 4 bytes, least significant byte first; the last byte SHALL carry pkt_out_eop=1.
REQ-024 IFG SHALL hold pkt_out_valid=0 and pkt_in_ready=0 for IFG_BYTES cycles, increment frame_cnt once, then return to IDLE.
REQ-025 frame_cnt SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-026 While rst_n=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, and the CRC SHALL be 0xFFFFFFFF.
REQ-027 A reset asserted mid-frame SHALL abort the frame immediately, with no eop emitted.
REQ-028 After rst_n rises, the first accepted sop SHALL start a fresh frame.

Configuration
REQ-029 The macro PEG_L2_MAC_TX_PAD_EN SHALL control padding of short frames.
REQ-030 With PEG_L2_MAC_TX_PAD_EN defined, frames shorter than 60 bytes SHALL be padded as in REQ-020 and REQ-021.
REQ-031 With PEG_L2_MAC_TX_PAD_EN undefined, the PAD state and its logic SHALL be absent, and DATA SHALL go directly to FCS.

Structure
REQ-032 Package peg_l2_pkg SHALL hold the FSM state enum and the constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, MIN_PAYLOAD=60, CRC_POLY, CRC_INIT and FCS_LEN=4.
REQ-033 The byte-wise CRC-32 update SHALL be the sub-module peg_l2_crc32_gen, with inputs init, byte_valid and byte, and a 32-bit crc output.

Verification
REQ-034 With padding off, payload "123456789" (9 bytes) SHALL produce 7x0x55, 0xD5, the payload, then FCS 0x26 0x39 0xF4 0xCB with eop on 0xCB.
REQ-035 With padding on, a 1-byte frame with sop and eop both set SHALL produce 8+1+59+4 = 72 output bytes with the FCS matching the reference model.
REQ-036 A 64-byte frame driven with pkt_out_ready toggling 1,0 SHALL be output with no loss or duplication, and data SHALL be held stable during each ready=0 cycle.
REQ-037 Two back-to-back frames SHALL have exactly 12 cycles of pkt_out_valid=0 between the first frame's eop and the second frame's sop, with frame_cnt stepping 0 -> 1 -> 2.
REQ-038 Asserting rst_n=0 at payload byte 20 SHALL drive outputs to 0 immediately; the next frame SHALL then be output with a correct FCS.
REQ-039 Three orphan bytes driven in IDLE with sop=0 SHALL be accepted and dropped, with no pkt_out_valid.

Source files
------------

// File: rtl/peg_l2_pkg.sv
// rtl/peg_l2_pkg.sv - shared FSM states, framing constants and CRC-32 byte step for the L2 MAC TX framer
package peg_l2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [10:0] MIN_PAYLOAD   = 11'd60;
    // 0x04C11DB7 bit-reversed, for the LSB-first (reflected) shift
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam int          FCS_LEN       = 4;
    localparam int          PRE_LEN       = 7;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/peg_l2_crc32_gen.sv
// rtl/peg_l2_crc32_gen.sv - registered byte-wise reflected CRC-32 accumulator
module peg_l2_crc32_gen
    import peg_l2_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] crc
);

    // init wins over a same-cycle byte so a new frame always starts clean
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else if (init) begin
            crc <= CRC_INIT;
        end else if (byte_valid) begin
            crc <= crc32_byte(crc, byte_data);
        end
    end

endmodule

// File: rtl/peg_l2_mac_tx_framer.sv
// rtl/peg_l2_mac_tx_framer.sv - MAC TX framer: preamble/SFD, payload, optional pad (PEG_L2_MAC_TX_PAD_EN), FCS, IFG
module peg_l2_mac_tx_framer
    import peg_l2_pkg::*;
#(
    parameter int PKT_DATA_W = 8,
    parameter int IFG_BYTES  = 12
) (
    input  logic                  rmii_ref_clk,
    input  logic                  rst_n,
    input  logic                  pkt_in_valid,
    input  logic                  pkt_in_sop,
    input  logic                  pkt_in_eop,
    input  logic [PKT_DATA_W-1:0] pkt_in_data,
    output logic                  pkt_in_ready,
    output logic                  pkt_out_valid,
    output logic                  pkt_out_sop,
    output logic                  pkt_out_eop,
    output logic [PKT_DATA_W-1:0] pkt_out_data,
    input  logic                  pkt_out_ready,
    output logic [15:0]           frame_cnt
);

    // The IDLE cycle that sees the next sop is the last idle byte-time,
    // so IFG itself only needs IFG_BYTES-1 empty cycles.
    localparam logic [7:0] IFG_LAST = 8'((IFG_BYTES > 1) ? IFG_BYTES - 2 : 0);

    tx_state_t state, state_next;

    logic [2:0]  pre_cnt;
    logic [10:0] byte_cnt, cnt_next;
    logic [1:0]  fcs_idx;
    logic [7:0]  ifg_cnt;
    logic [31:0] crc, fcs;
    logic [7:0]  fcs_byte;
    logic        out_free;

    logic                  ld, ld_sop, ld_eop;
    logic [PKT_DATA_W-1:0] ld_data;
    logic                  ready_c, frame_start, crc_valid;
    logic                  pre_inc, cnt_inc, fcs_inc, ifg_clr, ifg_inc, frame_inc;

    assign out_free     = !pkt_out_valid || pkt_out_ready;
    assign cnt_next     = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
    assign fcs          = ~crc;
    assign fcs_byte     = fcs[{fcs_idx, 3'b000} +: 8];
    assign pkt_in_ready = rst_n && ready_c;

    peg_l2_crc32_gen u_crc (
        .clk        (rmii_ref_clk),
        .rst_n      (rst_n),
        .init       (frame_start),
        .byte_valid (crc_valid),
        .byte_data  (ld_data),
        .crc        (crc)
    );

    // FSM state register
    always_ff @(posedge rmii_ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state, input handshake and output-register load decisions
    always_comb begin
        state_next  = state;
        ready_c     = 1'b0;
        ld          = 1'b0;
        ld_sop      = 1'b0;
        ld_eop      = 1'b0;
        ld_data     = '0;
        frame_start = 1'b0;
        crc_valid   = 1'b0;
        pre_inc     = 1'b0;
        cnt_inc     = 1'b0;
        fcs_inc     = 1'b0;
        ifg_clr     = 1'b0;
        ifg_inc     = 1'b0;
        frame_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                ready_c = pkt_in_valid && !pkt_in_sop;
                if (pkt_in_valid && pkt_in_sop) begin
                    ld          = 1'b1;
                    ld_sop      = 1'b1;
                    ld_data     = PREAMBLE_BYTE;
                    frame_start = 1'b1;
                    state_next  = ST_PRE;
                end
            end
            ST_PRE: begin
                if (out_free) begin
                    ld      = 1'b1;
                    ld_data = PREAMBLE_BYTE;
                    pre_inc = 1'b1;
                    if (pre_cnt == 3'(PRE_LEN - 1)) begin
                        state_next = ST_SFD;
                    end
                end
            end
            ST_SFD: begin
                if (out_free) begin
                    ld         = 1'b1;
                    ld_data    = SFD_BYTE;
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                ready_c = out_free;
                if (pkt_in_valid && out_free) begin
                    ld        = 1'b1;
                    ld_data   = pkt_in_data;
                    crc_valid = 1'b1;
                    cnt_inc   = 1'b1;
                    // a later sop means the client started a new frame: close this one
                    if (pkt_in_eop || (pkt_in_sop && byte_cnt != 11'd0)) begin
`ifdef PEG_L2_MAC_TX_PAD_EN
                        state_next = (cnt_next < MIN_PAYLOAD) ? ST_PAD : ST_FCS;
`else
                        state_next = ST_FCS;
`endif
                    end
                end
            end
`ifdef PEG_L2_MAC_TX_PAD_EN
            ST_PAD: begin
                if (out_free) begin
                    ld        = 1'b1;
                    ld_data   = '0;
                    crc_valid = 1'b1;
                    cnt_inc   = 1'b1;
                    if (cnt_next >= MIN_PAYLOAD) begin
                        state_next = ST_FCS;
                    end
                end
            end
`endif
            ST_FCS: begin
                if (out_free) begin
                    ld      = 1'b1;
                    ld_data = fcs_byte;
                    fcs_inc = 1'b1;
                    if (fcs_idx == 2'(FCS_LEN - 1)) begin
                        ld_eop     = 1'b1;
                        ifg_clr    = 1'b1;
                        state_next = ST_IFG;
                    end
                end
            end
            ST_IFG: begin
                // gap is timed from the cycle the eop byte has left the register
                if (!pkt_out_valid) begin
                    ifg_inc = 1'b1;
                    if (ifg_cnt == IFG_LAST) begin
                        frame_inc  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // output register, per-frame counters and the wrapping frame counter
    always_ff @(posedge rmii_ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_out_valid <= 1'b0;
            pkt_out_sop   <= 1'b0;
            pkt_out_eop   <= 1'b0;
            pkt_out_data  <= '0;
            pre_cnt       <= '0;
            byte_cnt      <= '0;
            fcs_idx       <= '0;
            ifg_cnt       <= '0;
            frame_cnt     <= '0;
        end else begin
            if (ld) begin
                pkt_out_valid <= 1'b1;
                pkt_out_sop   <= ld_sop;
                pkt_out_eop   <= ld_eop;
                pkt_out_data  <= ld_data;
            end else if (pkt_out_ready) begin
                pkt_out_valid <= 1'b0;
                pkt_out_sop   <= 1'b0;
                pkt_out_eop   <= 1'b0;
            end
            if (frame_start) begin
                pre_cnt  <= 3'd1;
                byte_cnt <= '0;
                fcs_idx  <= '0;
            end else begin
                if (pre_inc) pre_cnt  <= pre_cnt + 3'd1;
                if (cnt_inc) byte_cnt <= cnt_next;
                if (fcs_inc) fcs_idx  <= fcs_idx + 2'd1;
            end
            if (ifg_clr) begin
                ifg_cnt <= '0;
            end else if (ifg_inc) begin
                ifg_cnt <= ifg_cnt + 8'd1;
            end
            if (frame_inc) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_peg_l2_mac_tx_framer.sv
// tb/tb_peg_l2_mac_tx_framer.sv - scoreboard bench for peg_l2_mac_tx_framer
module tb_peg_l2_mac_tx_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pkt_in_valid, pkt_in_sop, pkt_in_eop;
    logic [7:0]  pkt_in_data;
    logic        pkt_in_ready;
    logic        pkt_out_valid, pkt_out_sop, pkt_out_eop;
    logic [7:0]  pkt_out_data;
    logic        pkt_out_ready;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [9:0] exp_q[$];
    int         fcnt_q[$];
    logic [7:0] pl[$];
    logic [7:0] fr[$];

    bit   scb_on       = 1'b1;
    bit   gap_check_on = 1'b0;
    bit   toggle_mode  = 1'b0;
    int   frames_sent  = 0;
    int   abort_eops   = 0;
    int   last_len     = 0;
    int   valid_cycles = 0;
    int   frame_len    = 0;
    int   gap_cnt      = 0;
    bit   gap_armed    = 1'b0;
    bit   sof_armed    = 1'b1;
    bit   hold_pending = 1'b0;
    logic [9:0] held;

    peg_l2_mac_tx_framer dut (
        .rmii_ref_clk  (clk),
        .rst_n         (rst_n),
        .pkt_in_valid  (pkt_in_valid),
        .pkt_in_sop    (pkt_in_sop),
        .pkt_in_eop    (pkt_in_eop),
        .pkt_in_data   (pkt_in_data),
        .pkt_in_ready  (pkt_in_ready),
        .pkt_out_valid (pkt_out_valid),
        .pkt_out_sop   (pkt_out_sop),
        .pkt_out_eop   (pkt_out_eop),
        .pkt_out_data  (pkt_out_data),
        .pkt_out_ready (pkt_out_ready),
        .frame_cnt     (frame_cnt)
    );

    initial forever #5 clk = ~clk;

    initial begin
        pkt_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pkt_out_ready = toggle_mode ? ~pkt_out_ready : 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_fcs();
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (fr[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ fr[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic push_expected(input int n_used, input bit hand_en, input logic [31:0] hand_fcs);
        logic [31:0] f;
        fr = {};
        for (int i = 0; i < n_used; i++) fr.push_back(pl[i]);
`ifdef PEG_L2_MAC_TX_PAD_EN
        while (fr.size() < 60) fr.push_back(8'h00);
`endif
        for (int k = 0; k < 7; k++) exp_q.push_back({(k == 0), 1'b0, 8'h55});
        exp_q.push_back({2'b00, 8'hD5});
        foreach (fr[i]) exp_q.push_back({2'b00, fr[i]});
        f = hand_en ? hand_fcs : ref_fcs();
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, (k == 3), f[8*k +: 8]});
        fcnt_q.push_back(frames_sent);
        frames_sent++;
    endtask

    task automatic wait_accept(input string name);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < 3000) begin
            @(negedge clk);
            if (pkt_in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
            n++;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL %s: no pkt_in_ready within 3000 cycles", name);
        end
    endtask

    task automatic drive_frame(input int force_idx, input int abort_at);
        for (int i = 0; i < pl.size(); i++) begin
            pkt_in_valid = 1'b1;
            pkt_in_data  = pl[i];
            pkt_in_sop   = (i == 0) || (i == force_idx);
            pkt_in_eop   = (i == pl.size() - 1);
            wait_accept("in_accept");
            if (i == abort_at) begin
                rst_n = 1'b0;
                break;
            end
            if (i == force_idx) break;
        end
        pkt_in_valid = 1'b0;
        pkt_in_sop   = 1'b0;
        pkt_in_eop   = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        @(negedge clk);
        forever begin
            if (!rst_n) begin
                hold_pending = 1'b0;
                sof_armed    = 1'b1;
                gap_armed    = 1'b0;
                frame_len    = 0;
            end else begin
                if (hold_pending)
                    check("hold_stable", {22'd0, pkt_out_valid, pkt_out_sop, pkt_out_eop, pkt_out_data},
                          {22'd0, 1'b1, held});
                hold_pending = 1'b0;
                if (pkt_out_valid) begin
                    valid_cycles++;
                    if (pkt_out_sop && sof_armed) begin
                        sof_armed = 1'b0;
                        if (gap_armed && gap_check_on) check("ifg_gap", gap_cnt, 12);
                        gap_armed = 1'b0;
                        if (scb_on) begin
                            if (fcnt_q.size() == 0) begin
                                n_checks++;
                                $display("FAIL frame_cnt_at_sop: unexpected frame start");
                            end else begin
                                check("frame_cnt_at_sop", {16'd0, frame_cnt}, fcnt_q.pop_front());
                            end
                        end
                    end
                    if (pkt_out_ready) begin
                        frame_len++;
                        if (scb_on) begin
                            if (exp_q.size() == 0) begin
                                n_checks++;
                                $display("FAIL out_byte: unexpected byte 0x%0h sop=%0d eop=%0d",
                                         pkt_out_data, pkt_out_sop, pkt_out_eop);
                            end else begin
                                check("out_byte", {22'd0, pkt_out_sop, pkt_out_eop, pkt_out_data},
                                      {22'd0, exp_q.pop_front()});
                            end
                        end
                        if (pkt_out_eop) begin
                            last_len  = frame_len;
                            frame_len = 0;
                            sof_armed = 1'b1;
                            gap_armed = 1'b1;
                            gap_cnt   = 0;
                            if (!scb_on) abort_eops++;
                        end
                    end else begin
                        hold_pending = 1'b1;
                        held = {pkt_out_sop, pkt_out_eop, pkt_out_data};
                    end
                end else if (gap_armed) begin
                    gap_cnt++;
                end
            end
            @(negedge clk);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

    initial begin
        int vc;
        rst_n        = 1'b0;
        pkt_in_valid = 1'b1;
        pkt_in_sop   = 1'b0;
        pkt_in_eop   = 1'b0;
        pkt_in_data  = 8'hA5;

        // reset state, with an orphan-looking byte offered
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {7'd0, pkt_in_ready, pkt_out_valid, pkt_out_sop, pkt_out_eop, pkt_out_data, frame_cnt}, 32'd0);
        check("reset_crc", dut.crc, 32'hFFFFFFFF);
        @(posedge clk);
        #1;
        pkt_in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // three orphan bytes are swallowed in IDLE
        vc = valid_cycles;
        for (int i = 0; i < 3; i++) begin
            pkt_in_valid = 1'b1;
            pkt_in_sop   = 1'b0;
            pkt_in_data  = 8'hB0 + 8'(i);
            wait_accept("orphan_accept");
        end
        pkt_in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("orphan_no_output", valid_cycles, vc);

        // "123456789": sop seen in IDLE gives valid one cycle later, byte not consumed
        pl = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
`ifdef PEG_L2_MAC_TX_PAD_EN
        push_expected(9, 1'b0, 32'd0);
`else
        push_expected(9, 1'b1, 32'hCBF43926);
`endif
        pkt_in_valid = 1'b1;
        pkt_in_sop   = 1'b1;
        pkt_in_eop   = 1'b0;
        pkt_in_data  = pl[0];
        @(negedge clk);
        check("idle_sop_not_consumed", {30'd0, pkt_in_ready, pkt_out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("sop_valid_next_cycle", {30'd0, pkt_out_valid, pkt_out_sop}, 32'd3);
        drive_frame(-1, -1);
        wait_drain("drain_check_string");

        // single-byte frame, sop and eop together
        pl = {8'h5A};
        push_expected(1, 1'b0, 32'd0);
        drive_frame(-1, -1);
        wait_drain("drain_one_byte");
`ifdef PEG_L2_MAC_TX_PAD_EN
        check("one_byte_len", last_len, 72);
`else
        check("one_byte_len", last_len, 13);
`endif

        // 64-byte frame under 1,0 backpressure
        pl = {};
        for (int i = 0; i < 64; i++) pl.push_back(8'(i * 3 + 7));
        push_expected(64, 1'b0, 32'd0);
        toggle_mode = 1'b1;
        drive_frame(-1, -1);
        wait_drain("drain_backpressure");
        toggle_mode = 1'b0;
        check("len_64", last_len, 64 + 12);

        // sop on the 6th byte closes the frame there
        pl = {};
        for (int i = 0; i < 12; i++) pl.push_back(8'hC0 + 8'(i));
        push_expected(6, 1'b0, 32'd0);
        drive_frame(5, -1);
        wait_drain("drain_forced_eop");
        repeat (20) @(posedge clk);
        #1;
        check("frame_cnt_before_reset", {16'd0, frame_cnt}, frames_sent);

        // reset at payload byte 20 aborts without eop
        scb_on = 1'b0;
        pl = {};
        for (int i = 0; i < 40; i++) pl.push_back(8'(200 - i));
        drive_frame(-1, 20);
        #1;
        check("abort_outputs_zero", {7'd0, pkt_in_ready, pkt_out_valid, pkt_out_sop, pkt_out_eop, pkt_out_data, frame_cnt}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_eop", abort_eops, 0);
        exp_q       = {};
        fcnt_q      = {};
        frames_sent = 0;
        rst_n  = 1'b1;
        scb_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // fresh frames back to back: 12 idle cycles and frame_cnt 0 -> 1 -> 2
        gap_check_on = 1'b1;
        pl = {};
        for (int i = 0; i < 16; i++) pl.push_back(8'h10 + 8'(i));
        push_expected(16, 1'b0, 32'd0);
        drive_frame(-1, -1);
        pl = {};
        for (int i = 0; i < 8; i++) pl.push_back(8'hE0 ^ 8'(i * 5));
        push_expected(8, 1'b0, 32'd0);
        drive_frame(-1, -1);
        wait_drain("drain_back_to_back");
        repeat (20) @(posedge clk);
        #1;
        gap_check_on = 1'b0;
        check("frame_cnt_after_b2b", {16'd0, frame_cnt}, 2);
        check("fcnt_queue_empty", fcnt_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
